// File: rtl/cpu_sram_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like bus between instruction fetch and data memory.
// Optional macro SRAM_ARB_RR_EN selects round-robin tie-breaking; otherwise data wins ties.
module cpu_sram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [3:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              arb_busy,
    output logic [1:0]        arb_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [3:0]        cmd_size_q, cmd_size_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              grant_data;

`ifdef SRAM_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the requester not granted last time wins.
    always_comb begin
        if (inst_req && data_req) grant_data = ~last_q;
        else                      grant_data = data_req;
    end
`else
    always_comb grant_data = data_req;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_size_d  = cmd_size_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
`ifdef SRAM_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (inst_req || data_req) begin
                    state_d     = ST_ADDR;
                    owner_d     = grant_data;
                    cmd_wr_d    = grant_data ? data_wr    : inst_wr;
                    cmd_size_d  = grant_data ? data_size  : inst_size;
                    cmd_addr_d  = grant_data ? data_addr  : inst_addr;
                    cmd_wdata_d = grant_data ? data_wdata : inst_wdata;
`ifdef SRAM_ARB_RR_EN
                    last_d      = grant_data;
`endif
                end
            end
            ST_ADDR: if (bus_addr_ok) state_d = ST_DATA;
            ST_DATA: if (bus_data_ok) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus fields come only from the latched command, so requester changes cannot leak through.
    always_comb begin
        logic in_addr;
        logic in_data;
        in_addr      = (state_q == ST_ADDR);
        in_data      = (state_q == ST_DATA);
        bus_req      = in_addr;
        bus_wr       = in_addr & cmd_wr_q;
        bus_size     = in_addr ? cmd_size_q  : '0;
        bus_addr     = in_addr ? cmd_addr_q  : '0;
        bus_wdata    = in_addr ? cmd_wdata_q : '0;
        inst_addr_ok = in_addr & ~owner_q & bus_addr_ok;
        data_addr_ok = in_addr &  owner_q & bus_addr_ok;
        inst_data_ok = in_data & ~owner_q & bus_data_ok;
        data_data_ok = in_data &  owner_q & bus_data_ok;
        inst_rdata   = (in_data & ~owner_q) ? bus_rdata : '0;
        data_rdata   = (in_data &  owner_q) ? bus_rdata : '0;
        arb_busy     = (state_q != ST_IDLE);
        arb_state    = state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_size_q  <= '0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
`ifdef SRAM_ARB_RR_EN
            last_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_size_q  <= cmd_size_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
`ifdef SRAM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed testbench for cpu_sram_arbiter: inputs change 1ns after the rising edge,
// outputs are sampled 3ns after it.
module tb_cpu_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [3:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        bus_req, bus_wr;
    logic [3:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_addr_ok, bus_data_ok;
    logic        arb_busy;
    logic [1:0]  arb_state;

    int tests_run = 0;
    int tests_failed = 0;

    cpu_sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .arb_busy(arb_busy), .arb_state(arb_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {53'd0, bus_req, bus_wr, bus_size, inst_addr_ok, data_addr_ok,
                              inst_data_ok, data_data_ok, arb_busy}, 64'd0);
        check({tag, "_baddr"}, {32'd0, bus_addr}, 64'd0);
        check({tag, "_bwdata"}, {32'd0, bus_wdata}, 64'd0);
        check({tag, "_irdata"}, {32'd0, inst_rdata}, 64'd0);
        check({tag, "_drdata"}, {32'd0, data_rdata}, 64'd0);
        check({tag, "_state"}, {62'd0, arb_state}, 64'd0);
    endtask

    // Driver: entered at the first ADDR cycle, leaves at the following IDLE cycle.
    task automatic do_txn(input string tag, input bit own, input int a_wait, input int d_wait,
                          input logic [31:0] e_addr, input bit e_wr, input logic [3:0] e_size,
                          input logic [31:0] e_wdata, input logic [31:0] rd,
                          input bit abuse, input bit spur);
        for (int i = 0; i < a_wait; i++) begin
            bus_addr_ok = 1'b0;
            bus_data_ok = spur;
            bus_rdata   = 32'h5555_AAAA;
            if (abuse && i == 1) data_addr = 32'hFFFF_FFF0;
            settle();
            check({tag, "_wait_req"}, {63'd0, bus_req}, 64'd1);
            check({tag, "_wait_addr"}, {32'd0, bus_addr}, {32'd0, e_addr});
            check({tag, "_wait_oks"}, {60'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 64'd0);
            check({tag, "_wait_rdata"}, {inst_rdata, data_rdata}, 64'd0);
            check({tag, "_wait_state"}, {62'd0, arb_state}, 64'd1);
            tick();
        end
        bus_data_ok = 1'b0;
        bus_rdata   = 32'd0;
        bus_addr_ok = 1'b1;
        settle();
        check({tag, "_bus_ctl"}, {58'd0, bus_req, bus_wr, bus_size}, {58'd0, 1'b1, e_wr, e_size});
        check({tag, "_bus_addr"}, {32'd0, bus_addr}, {32'd0, e_addr});
        check({tag, "_bus_wdata"}, {32'd0, bus_wdata}, {32'd0, e_wdata});
        check({tag, "_addr_ok"}, {62'd0, inst_addr_ok, data_addr_ok}, own ? 64'd1 : 64'd2);
        tick();
        bus_addr_ok = 1'b0;
        if (own) data_req = 1'b0;
        else     inst_req = 1'b0;
        for (int i = 0; i < d_wait; i++) begin
            settle();
            check({tag, "_dwait"}, {59'd0, bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 64'd0);
            check({tag, "_dwait_state"}, {62'd0, arb_state}, 64'd2);
            tick();
        end
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        settle();
        check({tag, "_data_ok"}, {62'd0, inst_data_ok, data_data_ok}, own ? 64'd1 : 64'd2);
        check({tag, "_irdata"}, {32'd0, inst_rdata}, own ? 64'd0 : {32'd0, rd});
        check({tag, "_drdata"}, {32'd0, data_rdata}, own ? {32'd0, rd} : 64'd0);
        tick();
        bus_data_ok = 1'b0;
        bus_rdata   = 32'd0;
    endtask

    initial begin
        reset = 1'b1;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 4'hF; inst_addr = 32'h0000_BFC0; inst_wdata = 32'd0;
        data_req = 1'b1; data_wr = 1'b1; data_size = 4'h3; data_addr = 32'h0000_0200;
        data_wdata = 32'h1234_5678;

        // Reset held two cycles with both requests high
        tick(); settle(); check_quiet("rst1");
        tick(); settle(); check_quiet("rst2");
        reset = 1'b0;
        settle();
        check("rel_idle", {62'd0, arb_state}, 64'd0);
        check("rel_noreq", {63'd0, bus_req}, 64'd0);
        tick();

        // Tie from reset: data first, then inst
        do_txn("tie1", 1'b1, 0, 0, 32'h0000_0200, 1'b1, 4'h3, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        settle();
        check("tie_gap", {62'd0, arb_state}, 64'd0);
        tick();
        do_txn("tie2", 1'b0, 0, 0, 32'h0000_BFC0, 1'b0, 4'hF, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b0);

        // Third tie goes to data in both builds
        inst_req = 1'b1; data_req = 1'b1;
        settle();
        check("tie3_idle", {63'd0, arb_busy}, 64'd0);
        tick();
        do_txn("tie3", 1'b1, 0, 0, 32'h0000_0200, 1'b1, 4'h3, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        tick();
        do_txn("tie4", 1'b0, 0, 0, 32'h0000_BFC0, 1'b0, 4'hF, 32'd0, 32'h0BAD_F00D, 1'b0, 1'b0);

        // Single data read
        data_req = 1'b1; data_wr = 1'b0; data_size = 4'hF; data_addr = 32'h0000_0100; data_wdata = 32'd0;
        tick();
        do_txn("rd", 1'b1, 1, 1, 32'h0000_0100, 1'b0, 4'hF, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Stalled addr_ok while the requester changes its address
        data_req = 1'b1; data_addr = 32'h0000_0300;
        tick();
        do_txn("stall", 1'b1, 5, 0, 32'h0000_0300, 1'b0, 4'hF, 32'd0, 32'h0000_0077, 1'b1, 1'b0);

        // Spurious bus_data_ok in IDLE, then in ADDR
        data_addr = 32'h0000_0400;
        bus_data_ok = 1'b1; bus_rdata = 32'hA5A5_A5A5;
        settle();
        check_quiet("spur_idle");
        tick();
        bus_data_ok = 1'b0; bus_rdata = 32'd0;
        settle();
        check("spur_idle_after", {62'd0, arb_state}, 64'd0);
        data_req = 1'b1;
        tick();
        do_txn("spur_addr", 1'b1, 2, 0, 32'h0000_0400, 1'b0, 4'hF, 32'd0, 32'h0000_4444, 1'b0, 1'b1);

        // Reset asserted in DATA
        data_req = 1'b1; data_addr = 32'h0000_0500;
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0; data_req = 1'b0;
        settle();
        check("rstd_in_data", {62'd0, arb_state}, 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_data_ok = 1'b1; bus_rdata = 32'h0000_0BAD;
        settle();
        check_quiet("rstd_late");
        tick();
        bus_data_ok = 1'b0; bus_rdata = 32'd0;
        data_req = 1'b1; data_addr = 32'h0000_0600;
        settle();
        check("rstd_idle", {62'd0, arb_state}, 64'd0);
        tick();
        do_txn("rstd_new", 1'b1, 1, 0, 32'h0000_0600, 1'b0, 4'hF, 32'd0, 32'h6666_0000, 1'b0, 1'b0);
        settle();
        check_quiet("end");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
